// File: rtl/tone_pkg.sv
// Shared note table and helpers for the tone generator and the melody sequencer.
package tone_pkg;

  localparam int NUM_NOTES   = 21;
  localparam int FREQ_W      = 11;
  localparam int TABLE_IDX_W = 5;

  // Index 0 and entries beyond the last note are zero so any 5-bit index is safe.
  localparam logic [FREQ_W-1:0] NOTE_FREQ [0:31] = '{
    11'd0,    11'd262,  11'd294,  11'd330,  11'd349,  11'd392,  11'd440,  11'd494,
    11'd523,  11'd587,  11'd659,  11'd699,  11'd784,  11'd880,  11'd988,  11'd1050,
    11'd1175, 11'd1319, 11'd1397, 11'd1568, 11'd1760, 11'd1976, 11'd0,    11'd0,
    11'd0,    11'd0,    11'd0,    11'd0,    11'd0,    11'd0,    11'd0,    11'd0
  };

  function automatic logic note_is_mute(input logic [31:0] note, input int num_notes);
    return (note == 32'd0) || (note > 32'(num_notes)) || (note > 32'(NUM_NOTES));
  endfunction

endpackage

// File: rtl/tone_divgen_if.sv
// Note request / tone status bundle between the melody sequencer and tone_divgen.
interface tone_divgen_if #(
  parameter int NOTE_W = 5,
  parameter int DIV_W  = 32
);

  logic [NOTE_W-1:0] note_in;
  logic              note_valid;
  logic              note_ready;
  logic              busy;
  logic [DIV_W-1:0]  divnum_out;
  logic              divnum_valid;
  logic              tone_out;
  logic              active;

  modport master (
    output note_in, note_valid,
    input  note_ready, busy, divnum_out, divnum_valid, tone_out, active
  );

  modport slave (
    input  note_in, note_valid,
    output note_ready, busy, divnum_out, divnum_valid, tone_out, active
  );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done is high on the
// cycle before the W+1-th edge after start, with the quotient valid alongside.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dsr;
  logic             running;
  logic [CNT_W-1:0] step;
  logic [W:0]       rem_shift;
  logic [W:0]       rem_sub;

  // A set top bit of the trial subtraction means the shifted remainder was smaller.
  assign rem_shift = {rem, quo[W-1]};
  assign rem_sub   = rem_shift - {1'b0, dsr};
  assign done      = running && (step == CNT_W'(W));
  assign quotient  = quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      step    <= '0;
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      rem     <= '0;
      quo     <= dividend;
      dsr     <= divisor;
    end else if (done) begin
      running <= 1'b0;
    end else if (running) begin
      step <= step + CNT_W'(1);
      if (!rem_sub[W]) begin
        rem <= rem_sub[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= rem_shift[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/tone_divgen.sv
// Note index to half-period converter with square-wave tone output; the
// half-period CLK_HZ/(2*freq) comes from a shared sequential divider.
module tone_divgen
  import tone_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DIV_W     = 32,
  parameter int NOTE_W    = 5,
  parameter int NUM_NOTES = tone_pkg::NUM_NOTES
) (
  input  logic          clk,
  input  logic          rst,
  tone_divgen_if.slave  bus
);

  logic [NOTE_W-1:0]      note;
  logic [TABLE_IDX_W-1:0] tbl_idx;
  logic [FREQ_W-1:0]      freq;
  logic                   mute;
  logic                   accept;
  logic                   div_done;
  logic [DIV_W-1:0]       quotient;
  logic [DIV_W-1:0]       divnum;
  logic [DIV_W-1:0]       tone_cnt;
  logic                   busy_q;
  logic                   valid_q;
  logic                   tone_q;
  logic                   active_q;

  assign note    = bus.note_in;
  assign tbl_idx = TABLE_IDX_W'(note);
  assign freq    = NOTE_FREQ[tbl_idx];
  assign mute    = note_is_mute(32'(note), NUM_NOTES);
  assign accept  = bus.note_valid && !busy_q;

  seq_divider #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && !mute),
    .dividend (DIV_W'(CLK_HZ)),
    .divisor  (DIV_W'({freq, 1'b0})),
    .done     (div_done),
    .quotient (quotient)
  );

  // The old tone keeps sounding while a new half-period is being computed;
  // the new value takes over with a cleared counter but an unchanged level.
  always_ff @(posedge clk) begin
    if (rst) begin
      divnum   <= DIV_W'(CLK_HZ);
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      tone_q   <= 1'b0;
      active_q <= 1'b0;
      tone_cnt <= '0;
    end else begin
      valid_q <= 1'b0;
      if (div_done) begin
        divnum   <= (quotient == '0) ? DIV_W'(1) : quotient;
        valid_q  <= 1'b1;
        busy_q   <= 1'b0;
        active_q <= 1'b1;
        tone_cnt <= '0;
      end else begin
        if (accept && !mute) begin
          busy_q <= 1'b1;
        end
        if (accept && mute) begin
          active_q <= 1'b0;
          tone_q   <= 1'b0;
          tone_cnt <= '0;
        end else if (active_q) begin
          if (tone_cnt == divnum - DIV_W'(1)) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
          end else begin
            tone_cnt <= tone_cnt + DIV_W'(1);
          end
        end
      end
    end
  end

  assign bus.note_ready   = ~busy_q;
  assign bus.busy         = busy_q;
  assign bus.divnum_out   = divnum;
  assign bus.divnum_valid = valid_q;
  assign bus.tone_out     = tone_q;
  assign bus.active       = active_q;

endmodule

// File: tb/tb_tone_divgen.sv
// Scoreboard bench for tone_divgen: default 50 MHz instance plus a 10 kHz one
// whose short tone period can be measured end to end.
module tb_tone_divgen;

  localparam int CLK_HZ   = 50_000_000;
  localparam int CLK_HZ_S = 10_000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tone_divgen_if #(.NOTE_W(5), .DIV_W(32)) bus ();
  tone_divgen_if #(.NOTE_W(5), .DIV_W(16)) bus_s ();

  tone_divgen #(.CLK_HZ(CLK_HZ), .DIV_W(32), .NOTE_W(5), .NUM_NOTES(21)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tone_divgen #(.CLK_HZ(CLK_HZ_S), .DIV_W(16), .NOTE_W(5), .NUM_NOTES(21)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];

  int tb_freq [0:21] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659,
                         699, 784, 880, 988, 1050, 1175, 1319, 1397, 1568, 1760, 1976};

  function automatic int unsigned model_div(input int clk_hz, input int note);
    int unsigned q;
    q = int'(clk_hz) / (2 * tb_freq[note]);
    return (q == 0) ? 1 : q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a note for one accept edge; valid notes push their expected half-period.
  task automatic do_accept(input int note);
    bus.note_in    = 5'(note);
    bus.note_valid = 1'b1;
    checks++;
    if (bus.note_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_ready_n%0d: note_ready=%b expected 1", note, bus.note_ready);
    end
    tick();
    bus.note_valid = 1'b0;
    if (note >= 1 && note <= 21) begin
      exp_q.push_back(model_div(CLK_HZ, note));
      checks++;
      if (bus.busy !== 1'b1 || bus.note_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL accept_busy_n%0d: busy=%b note_ready=%b expected 1/0",
                 note, bus.busy, bus.note_ready);
      end
    end
  endtask

  task automatic wait_result(input string name);
    int k;
    bit seen;
    bit busy_ok;
    int unsigned exp;
    k = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (bus.divnum_valid === 1'b1) seen = 1'b1;
      else if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_timeout: no divnum_valid within %0d cycles, expected at cycle 33", name, k);
      return;
    end
    if (k != 33) begin
      errors++;
      $display("[TB] FAIL %s_latency: divnum_valid at cycle %0d expected 33", name, k);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_scoreboard: result %0d with no expected entry", name, bus.divnum_out);
    end else begin
      exp = exp_q.pop_front();
      if (bus.divnum_out !== exp) begin
        errors++;
        $display("[TB] FAIL %s_divnum: divnum_out=%0d expected %0d", name, bus.divnum_out, exp);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.note_ready !== 1'b1 || bus.active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done_flags: busy=%b note_ready=%b active=%b expected 0/1/1",
               name, bus.busy, bus.note_ready, bus.active);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("[TB] FAIL %s_busy_hold: busy=0 seen during divide, expected 1", name);
    end
    tick();
    checks++;
    if (bus.divnum_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_pulse_width: divnum_valid=%b one cycle later, expected 0", name, bus.divnum_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.note_in = '0;
    bus.note_valid = 1'b0;
    bus_s.note_in = '0;
    bus_s.note_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (bus.divnum_out !== 32'd50_000_000 || bus.note_ready !== 1'b1 || bus.tone_out !== 1'b0 ||
        bus.active !== 1'b0 || bus.divnum_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: divnum=%0d ready=%b tone=%b active=%b valid=%b busy=%b expected 50000000/1/0/0/0/0",
               bus.divnum_out, bus.note_ready, bus.tone_out, bus.active, bus.divnum_valid, bus.busy);
    end
  endtask

  task automatic test_divide_and_tone();
    int n;
    bit lvl;
    bit toggled;
    do_accept(6);
    wait_result("note6");
    lvl = bus.tone_out;
    n = 0;
    toggled = 1'b0;
    while (!toggled && n < 56830) begin
      tick();
      n++;
      if (bus.tone_out !== lvl) toggled = 1'b1;
    end
    checks++;
    if (!toggled || n + 1 != 56818) begin
      errors++;
      $display("[TB] FAIL tone_half_period: first toggle %0d cycles after update (toggled=%b) expected 56818",
               n + 1, toggled);
    end
  endtask

  task automatic test_low_high();
    do_accept(1);
    wait_result("note1");
    do_accept(21);
    wait_result("note21");
  endtask

  task automatic test_busy_ignore();
    do_accept(6);
    bus.note_in = 5'd13;
    bus.note_valid = 1'b1;
    checks++;
    if (bus.note_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_ready: note_ready=%b while dividing, expected 0", bus.note_ready);
    end
    wait_result("busy_first");
    exp_q.push_back(model_div(CLK_HZ, 13));
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_accept: busy=%b after held note, expected 1", bus.busy);
    end
    bus.note_valid = 1'b0;
    wait_result("held_note13");
  endtask

  task automatic test_mute();
    logic [31:0] prev;
    bit pulse;
    foreach (tb_freq[i]) begin
      if (i == 0 || i == 22) begin
        prev = bus.divnum_out;
        bus.note_in = 5'(i);
        bus.note_valid = 1'b1;
        tick();
        bus.note_valid = 1'b0;
        checks++;
        if (bus.active !== 1'b0 || bus.tone_out !== 1'b0 || bus.divnum_out !== prev ||
            bus.divnum_valid !== 1'b0 || bus.note_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL mute_n%0d: active=%b tone=%b divnum=%0d valid=%b ready=%b expected 0/0/%0d/0/1",
                   i, bus.active, bus.tone_out, bus.divnum_out, bus.divnum_valid, bus.note_ready, prev);
        end
      end
    end
    pulse = 1'b0;
    repeat (40) begin
      tick();
      if (bus.divnum_valid !== 1'b0 || bus.busy !== 1'b0) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin
      errors++;
      $display("[TB] FAIL mute0_no_pulse: divnum_valid or busy rose after mute, expected 0");
    end
    do_accept(21);
    wait_result("replay21");
    repeat (5) tick();
    prev = bus.divnum_out;
    bus.note_in = 5'd22;
    bus.note_valid = 1'b1;
    tick();
    bus.note_valid = 1'b0;
    checks++;
    if (bus.active !== 1'b0 || bus.tone_out !== 1'b0 || bus.divnum_out !== prev || bus.divnum_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mute_n22: active=%b tone=%b divnum=%0d valid=%b expected 0/0/%0d/0",
               bus.active, bus.tone_out, bus.divnum_out, bus.divnum_valid, prev);
    end
  endtask

  task automatic test_reset_mid();
    bit pulse;
    do_accept(1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.divnum_out !== 32'd50_000_000 || bus.busy !== 1'b0 || bus.note_ready !== 1'b1 ||
        bus.active !== 1'b0 || bus.tone_out !== 1'b0 || bus.divnum_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: divnum=%0d busy=%b ready=%b active=%b tone=%b valid=%b expected 50000000/0/1/0/0/0",
               bus.divnum_out, bus.busy, bus.note_ready, bus.active, bus.tone_out, bus.divnum_valid);
    end
    pulse = 1'b0;
    repeat (40) begin
      tick();
      if (bus.divnum_valid !== 1'b0) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_pulse: divnum_valid rose after aborted divide, expected 0");
    end
  endtask

  task automatic test_small_clock();
    int k;
    int n;
    int r1;
    int r2;
    bit prev;
    bus_s.note_in = 5'd6;
    bus_s.note_valid = 1'b1;
    tick();
    bus_s.note_valid = 1'b0;
    k = 0;
    while (bus_s.divnum_valid !== 1'b1 && k < 25) begin
      tick();
      k++;
    end
    checks++;
    if (bus_s.divnum_valid !== 1'b1 || k != 17) begin
      errors++;
      $display("[TB] FAIL small_latency: divnum_valid=%b at cycle %0d expected 1 at 17", bus_s.divnum_valid, k);
    end
    checks++;
    if (bus_s.divnum_out !== 16'(model_div(CLK_HZ_S, 6))) begin
      errors++;
      $display("[TB] FAIL small_divnum: divnum_out=%0d expected %0d", bus_s.divnum_out, model_div(CLK_HZ_S, 6));
    end
    r1 = -1;
    r2 = -1;
    n = 0;
    prev = bus_s.tone_out;
    while (r2 < 0 && n < 80) begin
      tick();
      n++;
      if (prev == 1'b0 && bus_s.tone_out === 1'b1) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
      end
      prev = bus_s.tone_out;
    end
    checks++;
    if (r1 != 11 || r2 - r1 != 22) begin
      errors++;
      $display("[TB] FAIL small_period: first rise %0d period %0d expected 11 and 22", r1, r2 - r1);
    end
    n = 0;
    while (bus_s.tone_out !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    bus_s.note_in = 5'd22;
    bus_s.note_valid = 1'b1;
    tick();
    bus_s.note_valid = 1'b0;
    checks++;
    if (bus_s.active !== 1'b0 || bus_s.tone_out !== 1'b0 || bus_s.divnum_out !== 16'd11) begin
      errors++;
      $display("[TB] FAIL small_mute: active=%b tone=%b divnum=%0d expected 0/0/11",
               bus_s.active, bus_s.tone_out, bus_s.divnum_out);
    end
  endtask

  initial begin
    test_reset();
    test_divide_and_tone();
    test_low_high();
    test_busy_ignore();
    test_mute();
    test_reset_mid();
    test_small_clock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
